// File: rtl/sensor_hub_if.sv
// sensor_hub_if: register-access bus of the sensor hub.
//   req    : access request, one access per cycle
//   we     : 1 = write, 0 = read
//   addr   : byte address (bits [1:0] ignored by the slave)
//   wdata  : write data
//   rdata  : registered read data, held between reads
//   rvalid : one-cycle pulse, the cycle after a read request
interface sensor_hub_if;
  logic        req;
  logic        we;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rvalid;

  modport master (output req, we, addr, wdata, input rdata, rvalid);
  modport slave  (input req, we, addr, wdata, output rdata, rvalid);
endinterface

// File: rtl/sensor_hub.sv
// sensor_hub: NCH-channel sensor acquisition hub with per-channel sample FIFOs,
// fill-threshold interrupts and a simple register bus.
//   clk, rstn        : single clock, synchronous active-low reset
//   bus (slave)      : register access (CTRL/MASK/STATUS/THRESH/DATA_i/COUNT_i)
//   sensor_en[i]     : channel i is acquiring
//   sensor_ready[i]  : channel i sample strobe
//   sensor_out       : samples, channel i at [i*DW +: DW]
//   sensor_interrupt : registered OR of unmasked pending bits
//
// sensor_hub_ch: one channel -- IDLE/ACQ/HOLD FSM plus a DEPTH-entry FIFO.
//   en_i/rdy_i/smp_i : CTRL bit, strobe and sample
//   pop_req_i        : DATA_i read this cycle (pops only when non-empty)
//   thresh_i         : fill threshold
//   sen_o/head_o/cnt_o/full_o : acquire enable, FIFO head (0 when empty),
//                               occupancy, full flag
//   pend_set_o       : count is stepping from thresh-1 to thresh this cycle
module sensor_hub_ch #(
  parameter int DEPTH = 8,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          en_i,
  input  logic          rdy_i,
  input  logic [DW-1:0] smp_i,
  input  logic          pop_req_i,
  input  logic [6:0]    thresh_i,
  output logic          sen_o,
  output logic [31:0]   head_o,
  output logic [6:0]    cnt_o,
  output logic          full_o,
  output logic          pend_set_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, ACQ = 2'd1, HOLD = 2'd2} st_e;

  st_e            st_q, st_d;
  logic [31:0]    mem_q [DEPTH];
  logic [AW-1:0]  wp_q, rp_q;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           push, pop, full;

  assign full = (cnt_q == CW'(DEPTH));
  // en_i gates the push so a sample arriving the cycle CTRL drops is lost
  // rather than landing while the FSM is still on its way to IDLE.
  assign push = rdy_i & en_i & (st_q == ACQ);
  assign pop  = pop_req_i & (cnt_q != '0);

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + CW'(1);
    else if (pop && !push) cnt_d = cnt_q - CW'(1);
  end

  always_comb begin
    st_d = st_q;
    if (!en_i) st_d = IDLE;
    else begin
      case (st_q)
        IDLE:    if (!full) st_d = ACQ;
        ACQ:     if (push && !pop && cnt_q == CW'(DEPTH - 1)) st_d = HOLD;
        HOLD:    if (pop) st_d = ACQ;
        default: st_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      st_q  <= IDLE;
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
      if (push) wp_q <= wp_q + AW'(1);
      if (pop)  rp_q <= rp_q + AW'(1);
    end
  end

  // Storage is not reset; pointers/count define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= 32'(smp_i);
  end

  assign sen_o      = en_i & (st_q == ACQ);
  assign head_o     = (cnt_q != '0) ? mem_q[rp_q] : 32'd0;
  assign cnt_o      = 7'(cnt_q);
  assign full_o     = full;
  // Only a net +1 step can cross upward; thresh 0 never matches cnt+1 and
  // thresh > DEPTH is unreachable, so no range check is needed.
  assign pend_set_o = push & ~pop & ((7'(cnt_q) + 7'd1) == thresh_i);
endmodule

module sensor_hub #(
  parameter int NCH   = 4,
  parameter int DEPTH = 8,
  parameter int DW    = 32
) (
  input  logic              clk,
  input  logic              rstn,
  sensor_hub_if.slave       bus,
  output logic [NCH-1:0]    sensor_en,
  input  logic [NCH-1:0]    sensor_ready,
  input  logic [NCH*DW-1:0] sensor_out,
  output logic              sensor_interrupt
);
  logic [5:0]            widx;
  logic                  wr, rd;
  logic [NCH-1:0]        ctrl_q, mask_q, pend_q, pend_d;
  logic [6:0]            thresh_q;
  logic                  irq_q, rvalid_q;
  logic [31:0]           rdata_q, rdata_d;
  logic [NCH-1:0]        pop_req, full, pset, clr;
  logic [NCH-1:0][31:0]  head;
  logic [NCH-1:0][6:0]   cnt;
  logic                  unused_bits;

  assign widx        = bus.addr[7:2];
  assign wr          = bus.req & bus.we;
  assign rd          = bus.req & ~bus.we;
  assign unused_bits = ^{bus.addr[1:0], bus.wdata};

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign pop_req[i] = rd && (widx == 6'(8 + i));
    sensor_hub_ch #(.DEPTH(DEPTH), .DW(DW)) u_ch (
      .clk        (clk),
      .rstn       (rstn),
      .en_i       (ctrl_q[i]),
      .rdy_i      (sensor_ready[i]),
      .smp_i      (sensor_out[i*DW +: DW]),
      .pop_req_i  (pop_req[i]),
      .thresh_i   (thresh_q),
      .sen_o      (sensor_en[i]),
      .head_o     (head[i]),
      .cnt_o      (cnt[i]),
      .full_o     (full[i]),
      .pend_set_o (pset[i])
    );
  end

  // W1C clear, with a same-cycle set taking priority.
  assign clr    = (wr && widx == 6'd2) ? bus.wdata[NCH-1:0] : '0;
  assign pend_d = (pend_q & ~clr) | pset;

  always_comb begin
    rdata_d = rdata_q;
    if (rd) begin
      rdata_d = '0;
      case (widx)
        6'd0: rdata_d[NCH-1:0] = ctrl_q;
        6'd1: rdata_d[NCH-1:0] = mask_q;
        6'd2: begin
          rdata_d[NCH-1:0]  = pend_q;
          rdata_d[8 +: NCH] = full;
        end
        6'd3: rdata_d[6:0] = thresh_q;
        default: begin
          for (int i = 0; i < NCH; i++) begin
            if (widx == 6'(8 + i))  rdata_d = head[i];
            if (widx == 6'(16 + i)) rdata_d = 32'(cnt[i]);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      ctrl_q   <= '0;
      mask_q   <= '0;
      thresh_q <= '0;
      pend_q   <= '0;
      irq_q    <= 1'b0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      if (wr && widx == 6'd0) ctrl_q   <= bus.wdata[NCH-1:0];
      if (wr && widx == 6'd1) mask_q   <= bus.wdata[NCH-1:0];
      if (wr && widx == 6'd3) thresh_q <= bus.wdata[6:0];
      pend_q   <= pend_d;
      irq_q    <= |(pend_q & mask_q);
      rdata_q  <= rdata_d;
      rvalid_q <= rd;
    end
  end

  assign bus.rdata        = rdata_q;
  assign bus.rvalid       = rvalid_q;
  assign sensor_interrupt = irq_q;
endmodule

// File: tb/tb_sensor_hub.sv
// tb_sensor_hub: directed vectors for sensor_hub; read expectations go into a
// scoreboard queue and a monitor compares them against each rvalid pulse.
module tb_sensor_hub;
  localparam int NCH = 4, DEPTH = 8, DW = 32;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  sensor_hub_if bus();
  logic [NCH-1:0]    sensor_en, sensor_ready;
  logic [NCH*DW-1:0] sensor_out;
  logic              sensor_interrupt;

  sensor_hub #(.NCH(NCH), .DEPTH(DEPTH), .DW(DW)) dut (
    .clk              (clk),
    .rstn             (rstn),
    .bus              (bus),
    .sensor_en        (sensor_en),
    .sensor_ready     (sensor_ready),
    .sensor_out       (sensor_out),
    .sensor_interrupt (sensor_interrupt)
  );

  int checks = 0, errors = 0;
  logic [31:0] exp_q[$];
  string       name_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every rvalid pulse consumes one scoreboard entry.
  always @(negedge clk) begin
    if (bus.rvalid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rvalid: got rdata %h with no read outstanding", bus.rdata);
      end else begin
        logic [31:0] e;
        string n;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        chk(n, bus.rdata, e);
      end
    end
  end

  task automatic cyc(input logic r, input logic w, input logic [7:0] a,
                     input logic [31:0] d, input logic [NCH-1:0] rdy);
    bus.req = r; bus.we = w; bus.addr = a; bus.wdata = d; sensor_ready = rdy;
    @(negedge clk);
    bus.req = 1'b0; bus.we = 1'b0; sensor_ready = '0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    cyc(1'b1, 1'b1, a, d, '0);
  endtask

  task automatic rd_rdy(input logic [7:0] a, input logic [31:0] e, input string nm,
                        input logic [NCH-1:0] rdy);
    exp_q.push_back(e);
    name_q.push_back(nm);
    cyc(1'b1, 1'b0, a, 32'd0, rdy);
  endtask

  task automatic rd(input logic [7:0] a, input logic [31:0] e, input string nm);
    rd_rdy(a, e, nm, '0);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 8'd0, 32'd0, '0);
  endtask

  task automatic smp(input int ch, input logic [31:0] v);
    logic [NCH-1:0] m;
    m = '0;
    m[ch] = 1'b1;
    sensor_out[ch*DW +: DW] = v;
    cyc(1'b0, 1'b0, 8'd0, 32'd0, m);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;
    sensor_ready = '0; sensor_out = '0;
    repeat (3) @(negedge clk);
    chk("rst_sensor_en", 32'(sensor_en), 0);
    chk("rst_irq", 32'(sensor_interrupt), 0);
    chk("rst_rvalid", 32'(bus.rvalid), 0);
    chk("rst_rdata", bus.rdata, 0);
    rstn = 1'b1;

    // Basic capture, threshold interrupt, readback.
    wr(8'h0C, 3); wr(8'h04, 1); wr(8'h00, 1); idle(1);
    chk("en_ch0_acq", 32'(sensor_en), 32'h1);
    smp(0, 32'hA1); smp(0, 32'hA2); smp(0, 32'hA3);
    chk("irq_not_yet", 32'(sensor_interrupt), 0);
    idle(1);
    chk("irq_set", 32'(sensor_interrupt), 1);
    rd(8'h08, 32'h1, "status_pend");
    rd(8'h40, 3, "count0_3");
    rd(8'h20, 32'hA1, "data0_a1");
    rd(8'h20, 32'hA2, "data0_a2");
    rd(8'h20, 32'hA3, "data0_a3");
    rd(8'h40, 0, "count0_drained");

    // W1C clear.
    wr(8'h08, 1); idle(1);
    chk("irq_cleared", 32'(sensor_interrupt), 0);
    rd(8'h08, 0, "status_cleared");

    // Set wins over same-cycle clear.
    smp(0, 32'hB1); smp(0, 32'hB2);
    sensor_out[31:0] = 32'hB3;
    cyc(1'b1, 1'b1, 8'h08, 32'h1, 4'b0001);
    rd(8'h08, 32'h1, "status_set_wins");
    chk("irq_set_wins", 32'(sensor_interrupt), 1);
    rd(8'h20, 32'hB1, "data0_b1");
    rd(8'h20, 32'hB2, "data0_b2");
    rd(8'h20, 32'hB3, "data0_b3");
    wr(8'h08, 1);

    // Overflow and recovery.
    wr(8'h0C, 0);
    for (int k = 1; k <= 10; k++) begin
      smp(0, 32'h100 + 32'(k));
      if (k == 7) chk("en_before_full", 32'(sensor_en[0]), 1);
      if (k == 8) chk("en_drop_full", 32'(sensor_en[0]), 0);
    end
    rd(8'h08, 32'h100, "status_full");
    rd(8'h40, 8, "count0_full");
    rd(8'h20, 32'h101, "ovf_pop1");
    chk("en_recover", 32'(sensor_en[0]), 1);
    rd(8'h20, 32'h102, "ovf_pop2");
    rd(8'h20, 32'h103, "ovf_pop3");
    rd(8'h20, 32'h104, "ovf_pop4");
    rd(8'h40, 4, "count0_4");

    // Simultaneous push and pop at count 4.
    sensor_out[31:0] = 32'h1AA;
    rd_rdy(8'h20, 32'h105, "pp_head", 4'b0001);
    rd(8'h40, 4, "count0_pp");
    rd(8'h20, 32'h106, "pp_d1");
    rd(8'h20, 32'h107, "pp_d2");
    rd(8'h20, 32'h108, "pp_d3");
    rd(8'h20, 32'h1AA, "pp_new");
    rd(8'h40, 0, "count0_pp_drained");

    // Empty / unmapped / out-of-range channel.
    rd(8'h24, 0, "data1_empty");
    rd(8'h44, 0, "count1_empty");
    wr(8'h14, 32'hFF);
    rd(8'h10, 0, "unmapped_10");
    rd(8'h30, 0, "data4_oob");
    rd(8'h50, 0, "count4_oob");
    rd(8'h00, 1, "ctrl_rb");
    rd(8'h04, 1, "mask_rb");
    rd(8'h0C, 0, "thresh_rb");

    // Multi-channel streaming.
    wr(8'h00, 32'hF); idle(1);
    chk("en_all", 32'(sensor_en), 32'hF);
    for (int r = 0; r < 4; r++) begin
      for (int ch = 0; ch < NCH; ch++)
        sensor_out[ch*DW +: DW] = 32'hC000_0000 | (32'(ch) << 8) | 32'(r);
      cyc(1'b0, 1'b0, 8'd0, 32'd0, (r == 3) ? 4'b0101 : 4'b1111);
    end
    for (int ch = 0; ch < NCH; ch++) begin
      int n;
      n = (ch % 2 == 0) ? 4 : 3;
      rd(8'(8'h40 + 4*ch), 32'(n), $sformatf("mc_count%0d", ch));
      for (int r = 0; r < n; r++)
        rd(8'(8'h20 + 4*ch), 32'hC000_0000 | (32'(ch) << 8) | 32'(r),
           $sformatf("mc_data%0d_%0d", ch, r));
    end

    // Reset mid-read with count 5.
    wr(8'h0C, 2); wr(8'h04, 4);
    for (int k = 1; k <= 5; k++) smp(2, 32'hD0 + 32'(k));
    chk("irq_pre_rst", 32'(sensor_interrupt), 1);
    rd(8'h48, 5, "count2_5");
    rstn = 1'b0;
    cyc(1'b1, 1'b0, 8'h28, 32'd0, 4'b0100);
    idle(1);
    chk("rst2_sensor_en", 32'(sensor_en), 0);
    chk("rst2_irq", 32'(sensor_interrupt), 0);
    chk("rst2_rvalid", 32'(bus.rvalid), 0);
    chk("rst2_rdata", bus.rdata, 0);
    rstn = 1'b1;
    rd(8'h48, 0, "count2_after_rst");
    rd(8'h08, 0, "status_after_rst");
    rd(8'h04, 0, "mask_after_rst");
    idle(2);
    chk("en_idle_after_rst", 32'(sensor_en), 0);

    idle(2);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d reads outstanding, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sensor_hub.md
SENSOR_HUB -- requirements
Module: sensor_hub

Interface
REQ-001 Parameter NCH, default 4, number of sensor channels, legal 1..8.
REQ-002 Parameter DEPTH, default 8, per-channel sample FIFO depth, power of two, legal 2..64.
REQ-003 Parameter DW, default 32, sample width, legal 1..32.
REQ-004 Clock and reset are fixed: single clock; reset synchronous, active-low.
  - clk  in  1  single clock; all logic on rising edge.
  - rstn  in  1  synchronous, active-low reset.
REQ-005 Register-access port:
  - req  in  1  access request, accepted every cycle.
  - we  in  1  1=write, 0=read.
  - addr  in  8  byte address; bits [1:0] ignored.
  - wdata  in  32  write data.
  - rdata  out  32  read data, registered.
  - rvalid  out  1  read data valid, one-cycle pulse.
REQ-006 Sensor port:
  - sensor_en  out  NCH  per-channel acquire enable.
  - sensor_ready  in  NCH  per-channel sample strobe.
  - sensor_out  in  NCH*DW  samples; channel i at [i*DW +: DW].
REQ-007 Interrupt port: sensor_interrupt  out  1  level interrupt.

Function
REQ-008 Register map:
  - 0x00 CTRL: bit i enables channel i; RW.
  - 0x04 MASK: bit i unmasks channel i interrupt; RW.
  - 0x08 STATUS: [NCH-1:0] pending, write-1-to-clear; [8+i] full, RO.
  - 0x0C THRESH: [6:0] fill threshold; RW.
  - 0x20+4i DATA_i: read pops channel i FIFO.
  - 0x40+4i COUNT_i: [6:0] channel i occupancy; RO.
REQ-009 Reads to unmapped addresses or channel index >= NCH return 0. Writes to those addresses are ignored.
REQ-010 Read timing: a read at cycle T returns rdata with rvalid=1 at T+1. rvalid=0 on all other cycles, and rdata is held.
REQ-011 Write timing: a write takes effect at the end of its request cycle.
REQ-012 Each channel has its own FSM with states IDLE, ACQ and HOLD. sensor_en[i]=1 only in ACQ.
REQ-013 FSM transitions:
  - IDLE->ACQ when CTRL[i]=1 and the FIFO is not full.
  - ACQ->HOLD when a push makes count==DEPTH.
  - HOLD->ACQ when a pop makes count<DEPTH and CTRL[i]=1.
  - Any state->IDLE when CTRL[i]=0.
REQ-014 Push: a push occurs when sensor_ready[i]=1 and state==ACQ. The channel-i slice of sensor_out, zero-extended to 32 bits, is written into the FIFO. sensor_ready in any other state is ignored and the sample is dropped.
REQ-015 Pop: a DATA_i read pops only if count>0. Reading an empty FIFO returns 0, leaves state unchanged and never underflows.
REQ-016 Simultaneous push and pop on one channel: the old head is read out, the new sample is written and count is unchanged. The FIFO wraps modulo DEPTH.
REQ-017 Count width is clog2(DEPTH)+1. Count never exceeds DEPTH and never goes below 0.
REQ-018 pending[i] is set on the cycle count transitions from THRESH-1 to THRESH, when THRESH is in 1..DEPTH. THRESH=0 or THRESH>DEPTH never sets pending.
REQ-019 If a set event and a W1C clear of the same bit occur in the same cycle, set wins.
REQ-020 sensor_interrupt = OR over i of (pending[i] & MASK[i]), registered; it appears one cycle after pending/MASK change.
REQ-021 Clearing CTRL[i] keeps FIFO contents and pending[i]. Any samples in flight are dropped.

Reset
REQ-022 With rstn=0 at a clk edge, the following are cleared:
  - CTRL, MASK, STATUS and THRESH to 0;
  - all FIFO pointers and counts to 0;
  - all FSMs to IDLE;
  - sensor_en, sensor_interrupt, rdata and rvalid to 0.
REQ-023 FIFO storage is not required to reset. Reset asserted mid-acquisition or mid-read aborts the operation, and no rvalid pulse follows.

Verification
REQ-024 Basic capture and readback:
  - Stimulus: THRESH=3, MASK=1, CTRL=1; three ch0 samples 0xA1, 0xA2, 0xA3.
  - Response: sensor_interrupt=1 one cycle after pending[0] sets.
  - Response: DATA_0 reads return 0xA1, 0xA2, 0xA3; COUNT_0=0 afterwards.
REQ-025 Overflow and recovery:
  - Stimulus: DEPTH=8, CTRL=1, 10 ch0 strobes.
  - Response: sensor_en[0] drops after the 8th push; STATUS[8]=1; samples 9-10 dropped.
  - Response: one DATA_0 pop -> sensor_en[0]=1 again.
REQ-026 Boundary cases:
  - Simultaneous push and pop at count=4 -> count stays 4 and order is preserved.
  - DATA_1 read when empty -> rdata=0 and count stays 0.
REQ-027 Interrupt clear:
  - Stimulus: write STATUS=1 while pending[0]=1.
  - Response: pending[0]=0 and the interrupt deasserts next cycle.
  - Stimulus: the same write in the same cycle as a threshold crossing.
  - Response: pending[0] remains 1.
REQ-028 Multi-channel and reset:
  - Stimulus: NCH=4, all channels streaming distinct patterns.
  - Response: no cross-channel corruption.
  - Stimulus: rstn=0 pulsed with count=5.
  - Response: all outputs 0, COUNT reads 0, FSMs IDLE.
